// File: rtl/register_serializer.sv
// Parallel-in/serial-out shifter for one WIDTH-bit word; out_valid rises the cycle after acceptance.
// The current bit holds while out_ready is low; in_ready is high only in IDLE, so upstream stalls while a word drains.
module register_serializer #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt,   cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          shreg_nxt = in_data;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          // Shift toward whichever end feeds out_bit, zero-filling behind.
          shreg_nxt = MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
          if (cnt == LAST) begin
            cnt_nxt   = '0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SHIFT);
  assign out_bit   = (state == SHIFT) && (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]);
  assign out_last  = (state == SHIFT) && (cnt == LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_register_serializer.sv
// Drives an LSB-first and an MSB-first serializer with shared stimulus and checks both
// every cycle against a bit-queue reference model, plus table vectors and corner sequences.
module tb_register_serializer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic in_ready0, out_bit0, out_valid0, out_last0, busy0, done0;
  logic in_ready1, out_bit1, out_valid1, out_last1, busy1, done1;

  always #5 clk = ~clk;

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0),
    .out_bit(out_bit0), .out_valid(out_valid0), .out_ready(out_ready), .out_last(out_last0),
    .busy(busy0), .done(done0)
  );

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready1),
    .out_bit(out_bit1), .out_valid(out_valid1), .out_ready(out_ready), .out_last(out_last1),
    .busy(busy1), .done(done1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the bits still to be sent, in send order, and a pending done cycle.
  bit mq0[$];
  bit mq1[$];
  bit mdone = 1'b0;

  typedef struct {
    logic [W-1:0] data;
    bit           first_lsb;
    bit           first_msb;
    int           ones;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(bit rst, bit iv, logic [W-1:0] d, bit ordy);
    bit b;
    if (rst) begin
      mq0.delete();
      mq1.delete();
      mdone = 1'b0;
    end else if (mdone) begin
      mdone = 1'b0;
    end else if (mq0.size() == 0) begin
      if (iv) begin
        for (int i = 0; i < W; i++) begin
          mq0.push_back(d[i]);
          mq1.push_back(d[W-1-i]);
        end
      end
    end else if (ordy) begin
      b = mq0.pop_front();
      b = mq1.pop_front();
      if (mq0.size() == 0) mdone = 1'b1;
    end
  endtask

  task automatic check_model();
    bit sh0, sh1;
    sh0 = (mq0.size() != 0);
    sh1 = (mq1.size() != 0);
    chk("in_ready0",  in_ready0,  !sh0 && !mdone);
    chk("out_valid0", out_valid0, sh0);
    chk("out_bit0",   out_bit0,   sh0 ? mq0[0] : 1'b0);
    chk("out_last0",  out_last0,  sh0 && (mq0.size() == 1));
    chk("busy0",      busy0,      sh0 || mdone);
    chk("done0",      done0,      mdone);
    chk("in_ready1",  in_ready1,  !sh1 && !mdone);
    chk("out_valid1", out_valid1, sh1);
    chk("out_bit1",   out_bit1,   sh1 ? mq1[0] : 1'b0);
    chk("out_last1",  out_last1,  sh1 && (mq1.size() == 1));
    chk("busy1",      busy1,      sh1 || mdone);
    chk("done1",      done1,      mdone);
  endtask

  // Apply inputs for the coming edge, advance the model, then sample on the falling edge.
  task automatic cycle(bit rst, bit iv, logic [W-1:0] d, bit ordy);
    reset     = rst;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    model_step(rst, iv, d, ordy);
    @(negedge clk);
    check_model();
  endtask

  int beats, ones0, ones1, lastbeat, donecyc, vcnt, dcnt, nacc;
  bit f0, f1;
  logic [7:0] seq;
  int acc[2];
  bit rdy;

  initial begin
    tbl[0] = '{32'h0000_0001, 1'b1, 1'b0, 1};
    tbl[1] = '{32'h8000_0000, 1'b0, 1'b1, 1};
    tbl[2] = '{32'hA5A5_A5A5, 1'b1, 1'b1, 16};
    tbl[3] = '{32'hFFFF_FFFF, 1'b1, 1'b1, 32};
    tbl[4] = '{32'h0000_0003, 1'b1, 1'b0, 2};
    tbl[5] = '{32'h0000_0000, 1'b0, 1'b0, 0};

    // Reset state
    cycle(1, 1, 32'hDEAD_BEEF, 1);
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_in_ready",  in_ready0,  1);
    chk("rst_done",      done0,      0);
    chk("rst_busy",      busy0,      0);
    cycle(0, 0, '0, 0);

    // Table vectors with out_ready held high
    for (int r = 0; r < 6; r++) begin
      beats = 0; ones0 = 0; ones1 = 0; lastbeat = 0; donecyc = -1; f0 = 0; f1 = 0;
      cycle(0, 1, tbl[r].data, 1);
      for (int c = 0; c < 40; c++) begin
        if (out_valid0) begin
          beats++;
          if (beats == 1) begin
            f0 = out_bit0;
            f1 = out_bit1;
          end
          ones0 += int'(out_bit0);
          ones1 += int'(out_bit1);
          if (out_last0) lastbeat = beats;
        end
        if (done0) donecyc = c;
        cycle(0, 0, '0, 1);
      end
      chk("tbl_beats",     beats,    32);
      chk("tbl_last_beat", lastbeat, 32);
      chk("tbl_done_cyc",  donecyc,  32);
      chk("tbl_first_lsb", f0,       tbl[r].first_lsb);
      chk("tbl_first_msb", f1,       tbl[r].first_msb);
      chk("tbl_ones_lsb",  ones0,    tbl[r].ones);
      chk("tbl_ones_msb",  ones1,    tbl[r].ones);
      chk("tbl_idle",      in_ready0, 1);
    end

    // A5A5_A5A5 with out_ready toggling, starting low on the first beat
    vcnt = 0; dcnt = 0; nacc = 0; seq = '0;
    cycle(0, 1, 32'hA5A5_A5A5, 1);
    for (int c = 0; c < 80; c++) begin
      rdy = (c % 2 == 1);
      if (out_valid0) vcnt++;
      if (done0) dcnt++;
      if (out_valid0 && rdy && nacc < 8) begin
        seq[nacc] = out_bit0;
        nacc++;
      end
      cycle(0, 0, '0, rdy);
    end
    chk("tog_shift_cycles", vcnt, 64);
    chk("tog_done_pulses",  dcnt, 1);
    chk("tog_first_byte",   seq,  8'hA5);

    // in_valid held high: consecutive accepts are 34 cycles apart
    nacc = 0; acc[0] = 0; acc[1] = 0;
    for (int c = 0; c < 60; c++) begin
      if (in_ready0 && nacc < 2) begin
        acc[nacc] = c;
        nacc++;
      end
      cycle(0, 1, (nacc <= 1 && acc[0] == c && c == 0) ? 32'hFFFF_FFFF : 32'h0, 1);
    end
    chk("hold_accepts",  nacc, 2);
    chk("hold_spacing",  acc[1] - acc[0], 34);
    for (int c = 0; c < 40; c++) cycle(0, 0, '0, 1);

    // Reset mid-word at cnt==10
    cycle(0, 1, 32'hFFFF_FFFF, 1);
    for (int c = 0; c < 10; c++) cycle(0, 0, '0, 1);
    cycle(1, 0, '0, 1);
    chk("midrst_out_valid", out_valid0, 0);
    chk("midrst_in_ready",  in_ready0,  1);
    chk("midrst_done",      done0,      0);
    cycle(0, 0, '0, 1);
    chk("midrst_no_done", done0, 0);
    cycle(0, 1, 32'h0000_0001, 1);
    chk("midrst_first_bit", out_bit0, 1);
    chk("midrst_valid",     out_valid0, 1);
    for (int c = 0; c < 36; c++) cycle(0, 0, '0, 1);

    // Sink stalled forever after accepting 3
    dcnt = 0;
    cycle(0, 1, 32'h0000_0003, 1);
    for (int c = 0; c < 100; c++) begin
      if (done0) dcnt++;
      cycle(0, 1, 32'hFFFF_0000, 0);
    end
    chk("stall_valid", out_valid0, 1);
    chk("stall_bit",   out_bit0,   1);
    chk("stall_last",  out_last0,  0);
    chk("stall_busy",  busy0,      1);
    chk("stall_done",  dcnt,       0);
    cycle(1, 0, '0, 0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 4000; c++) begin
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
